// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage_pkg
// Purpose : Shared types and constants for the MEM stage / MEM-WB segment:
//           handshake FSM state type, default link register, and the
//           byte-enable patterns driven onto the data-memory port.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    // Memory handshake FSM: IDLE issues a request combinationally, WAIT
    // holds it until the memory answers.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    localparam int unsigned LINK_REG_DEFAULT = 31;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_NONE = 4'b0000;

    // One-hot byte enable for a little-endian byte lane.
    function automatic logic [3:0] lane_be(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_load_align
// Purpose : Combinational load aligner. Picks the addressed byte out of the
//           read word for byte loads (sign- or zero-extended), or passes the
//           whole word through for word loads.
// Ports   : rdata   in  32  read word from data memory
//           lane    in   2  byte lane (little-endian address bits [1:0])
//           is_byte in   1  byte load
//           extop   in   1  sign-extend the byte when set
//           data    out 32  aligned load data
// Revision: 1.0 - initial release
// ============================================================================
module mem_load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic        is_byte,
    input  logic        extop,
    output logic [31:0] data
);

    logic [7:0] w_byte;

    always_comb begin
        w_byte = 8'h00;
        case (lane)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
    end

    assign data = is_byte ? {{24{extop & w_byte[7]}}, w_byte} : rdata;

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_wb_stage
// Purpose : Memory-access stage plus MEM/WB segment register. Issues word and
//           byte loads/stores to a handshaked data memory, stalls the pipe
//           while the memory is busy, selects destination register and
//           write-back value, and registers them on the falling clock edge.
// Config  : MEM_MISALIGN_TRAP_EN - when defined, misaligned word accesses are
//           trapped (no request, mem_exc pulsed); otherwise address bits
//           [1:0] are ignored for word accesses and mem_exc does not exist.
// Ports   : clk, rst_n             clock (negedge active), async low reset
//           pc_in, rt_in, rd_in    PC and register fields of the MEM instr
//           Result_in, busB_in     address / ALU result, store data
//           *_in control bits      from EX/MEM
//           dmem_*                 data-memory request/response port
//           mem_stall              freeze upstream pipeline
//           wb_regwr/wb_reg/wb_data  registered write-back outputs
//           mem_exc                registered misalignment flag (optional)
// Revision: 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter logic [4:0]  LINK_REG    = 5'(LINK_REG_DEFAULT),
    parameter logic [31:0] LINK_OFFSET = 32'd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic [4:0]  rt_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] Result_in,
    input  logic [31:0] busB_in,
    input  logic        RegDst_in,
    input  logic        MemtoReg_in,
    input  logic        RegWr_in,
    input  logic        MemWr_in,
    input  logic        ExtopM_in,
    input  logic        IsLink_in,
    input  logic        IsByteW_in,
    input  logic        IsByteB_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [29:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        mem_exc,
`endif
    output logic        wb_regwr,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);

    mem_state_t  r_state;

    logic        w_mem_op;
    logic        w_byte_acc;
    logic [1:0]  w_lane;
    logic        w_trap;
    logic [4:0]  w_dest;
    logic [31:0] w_load_data;
    logic [31:0] w_wb_val;
    logic        w_regwr;

    assign w_mem_op   = MemWr_in | MemtoReg_in;
    // Stores and loads use separate byte-size controls.
    assign w_byte_acc = MemWr_in ? IsByteW_in : IsByteB_in;
    assign w_lane     = Result_in[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_trap = w_mem_op & ~w_byte_acc & (w_lane != 2'b00);
`else
    assign w_trap = 1'b0;
`endif

    // In WAIT the upstream stages are frozen, so the inputs (and hence the
    // enables/data derived from them) are stable; only the request itself
    // is forced from state.
    assign dmem_req   = (r_state == WAIT) | (w_mem_op & ~w_trap);
    assign dmem_we    = MemWr_in & dmem_req;
    assign dmem_addr  = Result_in[31:2];
    assign dmem_be    = !dmem_req              ? BE_NONE :
                        (MemWr_in & IsByteW_in) ? lane_be(w_lane) : BE_WORD;
    assign dmem_wdata = IsByteW_in ? {4{busB_in[7:0]}} : busB_in;

    // dmem_ready only matters while a request is outstanding.
    assign mem_stall  = dmem_req & ~dmem_ready;

    mem_load_align u_load_align (
        .rdata   (dmem_rdata),
        .lane    (w_lane),
        .is_byte (IsByteB_in),
        .extop   (ExtopM_in),
        .data    (w_load_data)
    );

    assign w_dest   = IsLink_in ? LINK_REG : (RegDst_in ? rd_in : rt_in);
    assign w_wb_val = IsLink_in   ? (pc_in + LINK_OFFSET) :
                      MemtoReg_in ? w_load_data : Result_in;
    // Writes to $0 are suppressed here so the forwarding unit never sees them.
    assign w_regwr  = RegWr_in & (w_dest != 5'd0) & ~w_trap;

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (dmem_req && !dmem_ready) r_state <= WAIT;
                WAIT:    if (dmem_ready)              r_state <= IDLE;
                default:                              r_state <= IDLE;
            endcase
        end
    end

    // Segment register: a stall cycle inserts a bubble.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_regwr <= 1'b0;
            wb_reg   <= 5'd0;
            wb_data  <= 32'd0;
        end else if (mem_stall) begin
            wb_regwr <= 1'b0;
            wb_reg   <= 5'd0;
            wb_data  <= 32'd0;
        end else begin
            wb_regwr <= w_regwr;
            wb_reg   <= w_dest;
            wb_data  <= w_wb_val;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // A trapped access never stalls, so the flag lasts exactly one cycle.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_exc <= 1'b0;
        end else begin
            mem_exc <= w_trap & ~mem_stall;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_wb_stage
// Purpose : Self-checking bench for mem_wb_stage: directed cases followed by
//           random instructions against a behavioural reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_in, Result_in, busB_in;
    logic [4:0]  rt_in, rd_in;
    logic        RegDst_in, MemtoReg_in, RegWr_in, MemWr_in;
    logic        ExtopM_in, IsLink_in, IsByteW_in, IsByteB_in;
    logic        dmem_req, dmem_we, dmem_ready, mem_stall;
    logic [29:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata, dmem_rdata;
    logic        wb_regwr;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        mem_exc;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_wb_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc_in      (pc_in),
        .rt_in      (rt_in),
        .rd_in      (rd_in),
        .Result_in  (Result_in),
        .busB_in    (busB_in),
        .RegDst_in  (RegDst_in),
        .MemtoReg_in(MemtoReg_in),
        .RegWr_in   (RegWr_in),
        .MemWr_in   (MemWr_in),
        .ExtopM_in  (ExtopM_in),
        .IsLink_in  (IsLink_in),
        .IsByteW_in (IsByteW_in),
        .IsByteB_in (IsByteB_in),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_be    (dmem_be),
        .dmem_wdata (dmem_wdata),
        .dmem_ready (dmem_ready),
        .dmem_rdata (dmem_rdata),
        .mem_stall  (mem_stall),
`ifdef MEM_MISALIGN_TRAP_EN
        .mem_exc    (mem_exc),
`endif
        .wb_regwr   (wb_regwr),
        .wb_reg     (wb_reg),
        .wb_data    (wb_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        pc_in = 0; Result_in = 0; busB_in = 0; rt_in = 0; rd_in = 0;
        RegDst_in = 0; MemtoReg_in = 0; RegWr_in = 0; MemWr_in = 0;
        ExtopM_in = 0; IsLink_in = 0; IsByteW_in = 0; IsByteB_in = 0;
    endtask

    // Reference: what a load returns given the memory word.
    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [31:0] addr,
                                               input bit is_byte, input bit sext);
        int unsigned b;
        if (!is_byte) return word;
        b = (word >> ((addr % 4) * 8)) % 256;
        if (sext && b >= 128) return 32'(b) - 32'd256;
        return 32'(b);
    endfunction

    // Run the instruction currently on the inputs; memory answers after
    // 'waits' not-ready cycles with 'word'. Returns the number of stall
    // cycles observed.
    task automatic run_instr(input int waits, input logic [31:0] word, output int stalls);
        bit          mem_op, is_byte, trap, req_exp, stall_exp;
        int          dest;
        logic [31:0] val;
        mem_op  = MemWr_in || MemtoReg_in;
        is_byte = MemWr_in ? IsByteW_in : IsByteB_in;
`ifdef MEM_MISALIGN_TRAP_EN
        trap    = mem_op && !is_byte && (Result_in % 4 != 0);
`else
        trap    = 0;
`endif
        req_exp = mem_op && !trap;
        if (!req_exp) waits = 0;
        dest    = IsLink_in ? 31 : (RegDst_in ? rd_in : rt_in);
        val     = IsLink_in ? pc_in + 32'd4 :
                  MemtoReg_in ? model_load(word, Result_in, IsByteB_in, ExtopM_in) : Result_in;
        stalls  = 0;
        for (int w = 0; w <= waits; w++) begin
            @(posedge clk);
            dmem_ready = req_exp ? (w == waits) : 1'($urandom_range(0, 1));
            dmem_rdata = (w == waits) ? word : $urandom;
            #1;
            stall_exp = req_exp && (w < waits);
            check("dmem_req", 32'(dmem_req), 32'(req_exp));
            check("dmem_we", 32'(dmem_we), 32'(req_exp && MemWr_in));
            check("mem_stall", 32'(mem_stall), 32'(stall_exp));
            if (mem_stall) stalls++;
            if (req_exp) begin
                check("dmem_addr", 32'(dmem_addr), Result_in / 4);
                check("dmem_be", 32'(dmem_be),
                      (MemWr_in && IsByteW_in) ? 32'(2 ** (Result_in % 4)) : 32'hF);
                if (MemWr_in)
                    check("dmem_wdata", dmem_wdata,
                          IsByteW_in ? (busB_in % 256) * 32'h01010101 : busB_in);
            end
            @(negedge clk);
            #1;
            if (stall_exp) begin
                check("bubble_regwr", 32'(wb_regwr), 0);
                check("bubble_reg", 32'(wb_reg), 0);
                check("bubble_data", wb_data, 0);
            end else begin
                check("wb_regwr", 32'(wb_regwr), 32'(RegWr_in && dest != 0 && !trap));
                if (!trap) begin
                    check("wb_reg", 32'(wb_reg), 32'(dest));
                    check("wb_data", wb_data, val);
                end
            end
`ifdef MEM_MISALIGN_TRAP_EN
            check("mem_exc", 32'(mem_exc), 32'(trap && !stall_exp));
`endif
        end
    endtask

    initial begin
        int          n;
        int          kind;
        logic [31:0] word;

        rst_n = 0;
        dmem_ready = 0;
        dmem_rdata = 0;
        clear_inputs();
        #2;
        check("rst_regwr", 32'(wb_regwr), 0);
        check("rst_reg", 32'(wb_reg), 0);
        check("rst_data", wb_data, 0);
        check("rst_req", 32'(dmem_req), 0);
        @(posedge clk);
        rst_n = 1;
        @(negedge clk); #1;

        // Zero-wait word load
        clear_inputs();
        MemtoReg_in = 1; RegWr_in = 1; Result_in = 32'h100; rt_in = 5;
        run_instr(0, 32'hDEADBEEF, n);
        check("zw_stalls", n, 0);
        check("zw_data", wb_data, 32'hDEADBEEF);
        check("zw_reg", 32'(wb_reg), 5);

        // Sign- and zero-extended byte load from lane 3
        clear_inputs();
        MemtoReg_in = 1; RegWr_in = 1; IsByteB_in = 1; ExtopM_in = 1;
        Result_in = 32'h103; rt_in = 7;
        run_instr(0, 32'h80FFFFFF, n);
        check("lb_sext", wb_data, 32'hFFFFFF80);
        ExtopM_in = 0;
        run_instr(0, 32'h80FFFFFF, n);
        check("lb_zext", wb_data, 32'h00000080);

        // Byte store to lane 2
        clear_inputs();
        MemWr_in = 1; IsByteW_in = 1; Result_in = 32'h202; busB_in = 32'h12345678;
        run_instr(0, 32'h0, n);
        check("sb_be", 32'(dmem_be), 32'h4);
        check("sb_wdata", dmem_wdata, 32'h78787878);
        check("sb_regwr", 32'(wb_regwr), 0);

        // Two-wait load
        clear_inputs();
        MemtoReg_in = 1; RegWr_in = 1; Result_in = 32'h400; rt_in = 9;
        run_instr(2, 32'hCAFEF00D, n);
        check("w2_stalls", n, 2);
        check("w2_data", wb_data, 32'hCAFEF00D);

        // Link
        clear_inputs();
        IsLink_in = 1; RegWr_in = 1; pc_in = 32'h3000;
        run_instr(0, 32'h0, n);
        check("link_reg", 32'(wb_reg), 31);
        check("link_data", wb_data, 32'h3004);

        // Write to $0 suppressed
        clear_inputs();
        RegWr_in = 1; Result_in = 32'h55; rt_in = 0;
        run_instr(0, 32'h0, n);
        check("r0_regwr", 32'(wb_regwr), 0);

        // Misaligned word load
        clear_inputs();
        MemtoReg_in = 1; RegWr_in = 1; Result_in = 32'h102; rt_in = 3;
        run_instr(1, 32'h11223344, n);

        // Reset during WAIT
        clear_inputs();
        MemtoReg_in = 1; RegWr_in = 1; Result_in = 32'h500; rt_in = 4;
        @(posedge clk);
        dmem_ready = 0;
        #1;
        check("rw_stall", 32'(mem_stall), 1);
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        check("rw_regwr", 32'(wb_regwr), 0);
        check("rw_reg", 32'(wb_reg), 0);
        check("rw_data", wb_data, 0);
        clear_inputs();
        #1;
        check("rw_req", 32'(dmem_req), 0);
        check("rw_stall_clr", 32'(mem_stall), 0);
        @(posedge clk);
        rst_n = 1;
        @(negedge clk); #1;

        // Random instruction mix
        for (int i = 0; i < 80; i++) begin
            clear_inputs();
            kind      = $urandom_range(0, 3);
            pc_in     = $urandom;
            Result_in = $urandom;
            busB_in   = $urandom;
            rt_in     = 5'($urandom);
            rd_in     = 5'($urandom);
            RegDst_in = 1'($urandom);
            RegWr_in  = 1'($urandom);
            ExtopM_in = 1'($urandom);
            case (kind)
                1: begin MemtoReg_in = 1; IsByteB_in = 1'($urandom); end
                2: begin MemWr_in = 1; IsByteW_in = 1'($urandom); end
                3: begin IsLink_in = 1; end
                default: ;
            endcase
            word = $urandom;
            run_instr($urandom_range(0, 3), word, n);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
